// File: rtl/gcd_pkg.sv
// Shared types and constants for the gcd core requester.
package gcd_pkg;

  // Operand/result width of the gcd core.
  localparam int GCD_W = 4;

  // Default number of WAIT cycles before the core is declared hung.
  localparam int GCD_TIMEOUT_DEFAULT = 63;

  // Requester control states.
  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    RECOVER,
    RESP
  } req_state_t;

  // A zero operand never lets the core terminate, so such pairs are answered locally.
  function automatic logic has_zero_operand(input logic [GCD_W-1:0] a,
                                            input logic [GCD_W-1:0] b);
    return (a == '0) || (b == '0);
  endfunction

endpackage

// File: rtl/gcd_req_timer.sv
// Saturating WAIT-cycle counter for the gcd requester watchdog.
// expired is asserted in the enabled cycle whose increment reaches TIMEOUT,
// so WAIT lasts exactly TIMEOUT cycles before the hang is declared.
module gcd_req_timer
  import gcd_pkg::*;
#(
  parameter int TIMEOUT = GCD_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;
  logic [CW:0]   count_inc;
  logic          at_limit;

  assign at_limit  = (count == CW'(TIMEOUT));
  assign count_inc = {1'b0, count} + (CW + 1)'(1);
  assign expired   = enable & (at_limit | (count_inc == (CW + 1)'(TIMEOUT)));

  // Count enabled cycles, restart on clear, hold once TIMEOUT is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !at_limit) begin
      count <= count_inc[CW-1:0];
    end
  end

endmodule

// File: rtl/gcd_requester.sv
// Initiator for the gcd core ena/rdy interface. Takes operand pairs from a
// valid/ready request stream, runs them through the core (or answers zero
// operands directly), and returns the result on a valid/ready response
// stream. A watchdog resets a core that never raises rdy and reports an error.
module gcd_requester
  import gcd_pkg::*;
#(
  parameter int W       = GCD_W,
  parameter int TIMEOUT = GCD_TIMEOUT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_gcd,
  output logic         rsp_err,
  output logic         core_ena,
  output logic [W-1:0] core_in1,
  output logic [W-1:0] core_in2,
  input  logic         core_rdy,
  input  logic [W-1:0] core_out,
  output logic         core_rst
);

  req_state_t state;
  logic       timer_expired;
  logic       zero_pair;

  // The watchdog restarts in START and counts only while waiting on the core.
  gcd_req_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == START),
    .enable  (state == WAIT),
    .expired (timer_expired)
  );

  assign req_ready = (state == IDLE);
  assign zero_pair = (req_a == '0) || (req_b == '0);

  // Request/response sequencing with registered core strobes and results.
  // core_ena and core_rst are set on the transition into START/RECOVER so
  // each is a single-cycle pulse aligned with that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_gcd   <= '0;
      rsp_err   <= 1'b0;
      core_ena  <= 1'b0;
      core_rst  <= 1'b0;
      core_in1  <= '0;
      core_in2  <= '0;
    end else begin
      core_ena <= 1'b0;
      core_rst <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            core_in1 <= req_a;
            core_in2 <= req_b;
            if (zero_pair) begin
              rsp_gcd   <= req_a | req_b;
              rsp_err   <= 1'b0;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              core_ena <= 1'b1;
              state    <= START;
            end
          end
        end
        START: begin
          state <= WAIT;
        end
        WAIT: begin
          // A result arriving in the timeout cycle still wins.
          if (core_rdy) begin
            rsp_gcd   <= core_out;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (timer_expired) begin
            rsp_gcd  <= '0;
            rsp_err  <= 1'b1;
            core_rst <= 1'b1;
            state    <= RECOVER;
          end
        end
        RECOVER: begin
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_requester.sv
// Bench for gcd_requester: a transaction-level gcd core stand-in, a
// scoreboard fed at request acceptance, and a monitor that checks each
// response (value, error flag, latency, core strobes) when it is accepted.
`timescale 1ns/1ps
module tb_gcd_requester;
  import gcd_pkg::*;

  localparam int W  = GCD_W;
  localparam int TO = 63;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_gcd;
  logic         rsp_err;
  logic         core_ena;
  logic [W-1:0] core_in1;
  logic [W-1:0] core_in2;
  logic         core_rdy;
  logic [W-1:0] core_out;
  logic         core_rst;

  gcd_requester #(.W(W), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_gcd   (rsp_gcd),
    .rsp_err   (rsp_err),
    .core_ena  (core_ena),
    .core_in1  (core_in1),
    .core_in2  (core_in2),
    .core_rdy  (core_rdy),
    .core_out  (core_out),
    .core_rst  (core_rst)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit core_hang = 1'b0;
  bit bp_en = 1'b0;
  bit rdy_force = 1'b1;
  bit spur = 1'b0;

  typedef struct {
    logic [W-1:0] gcd;
    logic         err;
    int           lat;
    int           ena_n;
    int           rst_n;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Number of subtract steps the core's subtractive algorithm takes.
  function automatic int sub_steps(input int a, input int b);
    int s = 0;
    if (a == 0 || b == 0) return 0;
    while (a != b) begin
      if (a > b) a -= b; else b -= a;
      s++;
    end
    return s;
  endfunction

  function automatic int euclid(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Expected response and timing for one accepted request.
  function automatic exp_t model(input int a, input int b, input bit hang);
    exp_t e;
    if (a == 0 || b == 0) begin
      e.gcd = W'(a | b); e.err = 1'b0; e.lat = 1; e.ena_n = 0; e.rst_n = 0;
    end else if (hang) begin
      e.gcd = '0; e.err = 1'b1; e.lat = TO + 3; e.ena_n = 1; e.rst_n = 1;
    end else begin
      e.gcd = W'(euclid(a, b)); e.err = 1'b0; e.lat = 5 + 3 * sub_steps(a, b);
      e.ena_n = 1; e.rst_n = 0;
    end
    return e;
  endfunction

  // Core stand-in: rdy lands 3 cycles after ena, plus 3 per subtract step.
  int           m_cnt = 0;
  logic         m_rdy = 1'b0;
  logic [W-1:0] m_out = '0;
  assign core_rdy = m_rdy | spur;
  assign core_out = spur ? {W{1'b1}} : m_out;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= 0;
      m_rdy <= 1'b0;
      m_out <= '0;
    end else begin
      m_rdy <= 1'b0;
      if (core_rst) begin
        m_cnt <= 0;
      end else if (core_ena) begin
        m_cnt <= core_hang ? 0 : 2 + 3 * sub_steps(int'(core_in1), int'(core_in2));
      end else if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_rdy <= 1'b1;
          m_out <= W'(euclid(int'(core_in1), int'(core_in2)));
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Response backpressure, changed just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (bp_en) rsp_ready = ($urandom_range(0, 2) != 0);
    else       rsp_ready = rdy_force;
  end

  // Monitor: observe strobes per transaction, compare on response handshake.
  int ena_n = 0, ena_off = 0, rst_n = 0, rst_off = 0, lat = 0;
  bit seen = 1'b0, ready_chk = 1'b0;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      ena_n = 0; rst_n = 0; seen = 1'b0; ready_chk = 1'b0;
    end else begin
      if (ready_chk) begin
        chk("req_ready_after_rsp", req_ready, 1);
        ready_chk = 1'b0;
      end
      if (core_ena) begin ena_n++; ena_off = cyc - acc_cyc; end
      if (core_rst) begin rst_n++; rst_off = cyc - acc_cyc; end
      if (rsp_valid && !seen) begin seen = 1'b1; lat = cyc - acc_cyc; end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_gcd", rsp_gcd, e.gcd);
          chk("rsp_err", rsp_err, e.err);
          chk("rsp_latency", lat, e.lat);
          chk("core_ena_count", ena_n, e.ena_n);
          if (e.ena_n == 1) chk("core_ena_cycle", ena_off, 1);
          chk("core_rst_count", rst_n, e.rst_n);
          if (e.rst_n == 1) chk("core_rst_cycle", rst_off, TO + 2);
        end
        ena_n = 0; rst_n = 0; seen = 1'b0; ready_chk = 1'b1;
      end
    end
  end

  task automatic send(input int a, input int b, input bit push);
    int waited = 0;
    req_a = W'(a);
    req_b = W'(b);
    req_valid = 1'b1;
    while (!req_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      chk("req_accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    acc_cyc = cyc;
    if (push) sb.push_back(model(a, b, core_hang));
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_gcd"},   rsp_gcd,   0);
    chk({tag, "_rsp_err"},   rsp_err,   0);
    chk({tag, "_core_ena"},  core_ena,  0);
    chk({tag, "_core_rst"},  core_rst,  0);
    chk({tag, "_core_in1"},  core_in1,  0);
    chk({tag, "_core_in2"},  core_in2,  0);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int   wait_n;
    bit   saw;
    logic [W-1:0] held;

    #1 rst = 1'b1;
    #2 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Directed: equal operands, two-step pair, long pair back-to-back.
    send(9, 9, 1);
    drain(100);
    send(6, 4, 1);
    send(15, 1, 1);
    drain(200);

    // Zero bypass.
    send(0, 7, 1);
    send(0, 0, 1);
    drain(50);

    // Hung core, then normal recovery.
    core_hang = 1'b1;
    send(5, 7, 1);
    drain(200);
    core_hang = 1'b0;
    send(3, 3, 1);
    drain(100);

    // Response held under backpressure; new request and spurious rdy ignored.
    rdy_force = 1'b0;
    @(negedge clk);
    send(5, 10, 1);
    wait_n = 0;
    while (!rsp_valid && wait_n < 200) begin
      @(negedge clk);
      wait_n++;
    end
    chk("hold_rsp_valid_seen", rsp_valid, 1);
    held = rsp_gcd;
    chk("hold_first_gcd", held, 5);
    req_a = 4'd3;
    req_b = 4'd3;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      spur = (i == 3);
      @(negedge clk);
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_gcd", rsp_gcd, 5);
      chk("hold_rsp_err", rsp_err, 0);
      chk("hold_req_ready", req_ready, 0);
    end
    spur = 1'b0;
    req_valid = 1'b0;
    rdy_force = 1'b1;
    drain(100);

    // Reset while waiting on the core: request dropped, then normal service.
    send(6, 4, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre_rst_busy", req_ready, 0);
    rst = 1'b1;
    #1 check_reset_outputs("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid || core_ena) saw = 1'b1;
    end
    chk("no_rsp_after_rst", saw, 0);
    send(8, 12, 1);
    drain(100);

    // Randomized requests with random response backpressure.
    bp_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int a, b;
      a = $urandom_range(1, 15);
      b = $urandom_range(1, 15);
      case ($urandom_range(0, 7))
        0: a = 0;
        1: b = 0;
        default: ;
      endcase
      send(a, b, 1);
    end
    drain(3000);
    bp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
